div_issue_ctrl: RTL

DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

---
 rtl/div_issue_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/div_issue_ctrl.sv
// Issue/writeback controller for the multi-cycle divider: latches one DIV/REM op,
// stalls the pipeline while the divider runs, and aborts on flush or watchdog expiry.
module div_issue_ctrl #(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] reg1_rdata_i,
    input  logic [31:0] reg2_rdata_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic        flush_i,
    input  logic        div_ready_i,
    input  logic [31:0] div_result_i,
    input  logic [4:0]  div_reg_waddr_i,
    output logic        div_start_o,
    output logic [31:0] div_dividend_o,
    output logic [31:0] div_divisor_o,
    output logic [2:0]  div_op_o,
    output logic [4:0]  div_reg_waddr_o,
    output logic        hold_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        timeout_o
);

    // state | meaning
    // IDLE  | waiting for a divide instruction in EX
    // RUN   | divider busy, pipeline held, watchdog counting
    // WB    | one-cycle regfile write of the captured result
    // ABORT | flush or watchdog: divider released, nothing written
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WB, S_ABORT} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_dividend;
    logic [31:0] r_divisor;
    logic [4:0]  r_waddr;
    logic [31:0] r_result;
    logic        r_timeout;

    logic w_accept;
    logic w_match;
    logic w_expire;

    assign w_accept = !rst && (r_state == S_IDLE) && inst_valid_i && !flush_i;
    assign w_match  = (r_state == S_RUN) && div_ready_i && (div_reg_waddr_i == r_waddr);
    assign w_expire = (r_state == S_RUN) && (r_cnt == 6'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Priority in RUN: flush beats a completing divider, which beats the watchdog.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_RUN;
            S_RUN: begin
                if (flush_i)       w_next = S_ABORT;
                else if (w_match)  w_next = S_WB;
                else if (w_expire) w_next = S_ABORT;
            end
            S_WB:    w_next = S_IDLE;
            S_ABORT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_op       <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_waddr    <= '0;
            r_result   <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op       <= op_i;
                r_dividend <= reg1_rdata_i;
                r_divisor  <= reg2_rdata_i;
                r_waddr    <= reg_waddr_i;
            end
            // Counter only advances in RUN; TIMEOUT <= 64 keeps it from wrapping.
            if (r_state == S_RUN) r_cnt <= r_cnt + 6'd1;
            else                  r_cnt <= '0;
            if (w_match && !flush_i) r_result <= div_result_i;
            r_timeout <= w_expire && !flush_i && !w_match;
        end
    end

    assign div_dividend_o  = r_dividend;
    assign div_divisor_o   = r_divisor;
    assign div_op_o        = r_op;
    assign div_reg_waddr_o = r_waddr;

    always_comb begin
        div_start_o = 1'b0;
        hold_o      = w_accept;
        reg_we_o    = 1'b0;
        reg_waddr_o = '0;
        reg_wdata_o = '0;
        timeout_o   = 1'b0;
        case (r_state)
            S_RUN: begin
                div_start_o = 1'b1;
                hold_o      = 1'b1;
            end
            S_WB: begin
                reg_we_o    = (r_waddr != 5'd0);
                reg_waddr_o = r_waddr;
                reg_wdata_o = (r_waddr != 5'd0) ? r_result : 32'd0;
            end
            S_ABORT: timeout_o = r_timeout;
            default: ;
        endcase
    end

endmodule
